// File: rtl/fetch_pkg.sv
`default_nettype none
// ==== fetch_pkg : shared fetch widths, reset/step defaults and fetch entry type (rev 1.0) ====
package fetch_pkg;

   localparam int          FETCH_DATA_W   = 16;
   localparam int          FETCH_ADDR_W   = 16;
   localparam int          FETCH_DEPTH    = 4;
   localparam int          FETCH_MEM_LAT  = 2;
   localparam int unsigned FETCH_RESET_PC = 0;
   localparam int unsigned FETCH_PC_STEP  = 2;

   typedef struct packed {
      logic [FETCH_DATA_W-1:0] insn;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ==== fetch_fifo : synchronous FIFO with push/pop/clear and entry count, async reset (rev 1.0) ====
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam int             PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Clear beats both push and pop; pop on an empty FIFO is ignored.
   assign do_push = push && !clear;
   assign do_pop  = pop && (count != '0) && !clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

   // The issuer reserves a slot before reading, so a push into a full FIFO is a design error.
   overflow_check: assert property (@(posedge clk) disable iff (rst)
      !(do_push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ==== fetch_queue : sequential instruction prefetch with credit-limited issue and redirect squash (rev 1.0) ====
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DATA_W   = FETCH_DATA_W,
   parameter int          ADDR_W   = FETCH_ADDR_W,
   parameter int          DEPTH    = FETCH_DEPTH,
   parameter int          MEM_LAT  = FETCH_MEM_LAT,
   parameter int unsigned RESET_PC = FETCH_RESET_PC,
   parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [ADDR_W-2:0]            mem_raddr,
   input  logic [DATA_W-1:0]            mem_rdata,
   input  logic                         halt,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_insn,
   output logic [ADDR_W-1:0]            out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int INF_W = $clog2(MEM_LAT + 1);

   typedef struct packed {
      logic [DATA_W-1:0] insn;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   logic [ADDR_W-1:0]  pc;
   logic [MEM_LAT-1:0] slot_valid;
   logic [ADDR_W-1:0]  slot_pc [MEM_LAT];
   logic [INF_W-1:0]   inflight;
   logic               issue;
   logic               land;
   entry_t             push_entry;
   entry_t             head_entry;
   logic               redirect_lsb_unused;

   assign redirect_lsb_unused = redirect_pc[0];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) inflight = inflight + INF_W'(slot_valid[i]);
   end

   // Buffered plus outstanding reads never exceed DEPTH, so every landing read has a slot.
   assign issue     = !halt && !redirect_valid &&
                      ((32'(occupancy) + 32'(inflight)) < 32'(DEPTH));
   assign land      = slot_valid[MEM_LAT-1] && !redirect_valid;
   assign mem_raddr = pc[ADDR_W-1:1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= ADDR_W'(RESET_PC);
         slot_valid <= '0;
         for (int i = 0; i < MEM_LAT; i++) slot_pc[i] <= '0;
      end else begin
         if (redirect_valid)
            pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
         else if (issue)
            pc <= pc + ADDR_W'(PC_STEP);
         slot_valid[0] <= issue;
         slot_pc[0]    <= pc;
         for (int i = 1; i < MEM_LAT; i++) begin
            slot_valid[i] <= slot_valid[i-1] && !redirect_valid;
            slot_pc[i]    <= slot_pc[i-1];
         end
      end
   end

   assign push_entry = '{insn: mem_rdata, pc: slot_pc[MEM_LAT-1]};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_valid),
      .push      (land),
      .push_data (push_entry),
      .pop       (out_ready),
      .head_data (head_entry),
      .count     (occupancy)
   );

   assign out_valid = (occupancy != '0);
   assign out_insn  = head_entry.insn;
   assign out_pc    = head_entry.pc;

endmodule
`default_nettype wire
